// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flags, ARM condition check,
// strobe gating and fetch/squash debug counters.
module cond_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondExReg,
  output logic [CNT_W-1:0] FetchCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  logic n, z, c, v;
  logic cond_ex;
  logic decode_pending;

  assign {n, z, c, v} = Flags;

  always_comb begin
    cond_ex = 1'b1;
    unique case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b1;
    endcase
  end

  // Flag writes use the live condition so a failed instruction
  // never disturbs NZCV.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags          <= 4'b0000;
      CondExReg      <= 1'b0;
      decode_pending <= 1'b0;
      FetchCnt       <= '0;
      SquashCnt      <= '0;
    end else begin
      CondExReg      <= cond_ex;
      decode_pending <= IRWrite;
      if (FlagW[1] && cond_ex) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && cond_ex) Flags[1:0] <= ALUFlags[1:0];
      if (IRWrite) FetchCnt <= FetchCnt + 1'b1;
      if (decode_pending && !cond_ex) SquashCnt <= SquashCnt + 1'b1;
    end
  end

  assign PCWrite  = NextPC | (PCS & CondExReg);
  assign RegWrite = RegW & CondExReg;
  assign MemWrite = MemW & CondExReg;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit, built with 4-bit counters
// so the fetch-counter wrap is reachable.
module tb_cond_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   Cond, ALUFlags;
  logic [1:0]   FlagW;
  logic         PCS, NextPC, RegW, MemW, IRWrite;
  logic         PCWrite, RegWrite, MemWrite, CondExReg;
  logic [3:0]   Flags;
  logic [W-1:0] FetchCnt, SquashCnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] tbl;

  cond_unit #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
    .CondExReg(CondExReg), .FetchCnt(FetchCnt),
    .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Cond = 4'b1110; ALUFlags = 4'b0; FlagW = 2'b00;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0; IRWrite = 0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Cond = 4'($urandom); ALUFlags = 4'($urandom);
      FlagW = 2'($urandom); PCS = 1'($urandom);
      NextPC = 1'($urandom); RegW = 1'($urandom);
      MemW = 1'($urandom); IRWrite = 1'($urandom);
      tick();
    end
    chk("rst_flags", 32'(Flags), 0);
    chk("rst_cer", 32'(CondExReg), 0);
    reset = 1'b1;
    idle();
    NextPC = 1; RegW = 1; MemW = 1;
    #1;
    chk("rel_fetch", 32'(FetchCnt), 0);
    chk("rel_squash", 32'(SquashCnt), 0);
    chk("rel_regw", 32'(RegWrite), 0);
    chk("rel_memw", 32'(MemWrite), 0);
    chk("rel_pcw", 32'(PCWrite), 1);
    idle();

    // failed EQ must not write flags
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    chk("flag_protect", 32'(Flags), 32'h0);

    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
    tick();
    chk("flag_nz", 32'(Flags), 32'hC);
    FlagW = 2'b01; ALUFlags = 4'b0001;
    tick();
    chk("flag_cv", 32'(Flags), 32'hD);
    idle();

    // store squash with Z=0, then pass with Z=1
    set_flags(4'b0000);
    Cond = 4'b0000;
    tick();
    MemW = 1; RegW = 1;
    #1;
    chk("st_squash", 32'(MemWrite), 0);
    chk("rw_squash", 32'(RegWrite), 0);
    MemW = 0; RegW = 0;
    set_flags(4'b0100);
    Cond = 4'b0000;
    tick();
    MemW = 1;
    #1;
    chk("st_pass", 32'(MemWrite), 1);
    MemW = 0;

    // branch gating with N=1 V=0
    set_flags(4'b1000);
    Cond = 4'b1011;
    tick();
    PCS = 1; NextPC = 0;
    #1;
    chk("br_lt", 32'(PCWrite), 1);
    Cond = 4'b1010;
    tick();
    chk("br_ge", 32'(PCWrite), 0);
    NextPC = 1;
    #1;
    chk("br_nextpc", 32'(PCWrite), 1);
    idle();

    // full condition table for two flag settings
    tbl = 16'hEA9A;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i);
      tick();
      chk($sformatf("cond_1000_%0d", i), 32'(CondExReg), 32'(tbl[i]));
    end
    set_flags(4'b0110);
    tbl = 16'hE6A5;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i);
      tick();
      chk($sformatf("cond_0110_%0d", i), 32'(CondExReg), 32'(tbl[i]));
    end
    idle();

    // counters
    set_flags(4'b0000);
    IRWrite = 1; Cond = 4'b1110; tick();
    IRWrite = 0; Cond = 4'b1110; tick();
    IRWrite = 1; Cond = 4'b1110; tick();
    IRWrite = 0; Cond = 4'b0000; tick();
    IRWrite = 1; Cond = 4'b1110; tick();
    IRWrite = 0; Cond = 4'b1111; tick();
    chk("cnt_fetch3", 32'(FetchCnt), 3);
    chk("cnt_squash1", 32'(SquashCnt), 1);
    IRWrite = 1; Cond = 4'b0000; tick();
    tick();
    IRWrite = 0; Cond = 4'b1110; tick();
    chk("b2b_fetch", 32'(FetchCnt), 5);
    chk("b2b_squash", 32'(SquashCnt), 2);
    IRWrite = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("fetch_max", 32'(FetchCnt), 15);
    tick();
    IRWrite = 0;
    chk("fetch_wrap", 32'(FetchCnt), 0);
    tick();
    chk("squash_hold", 32'(SquashCnt), 2);

    // asynchronous reset mid-instruction
    set_flags(4'b1111);
    tick();
    RegW = 1; MemW = 1;
    #1;
    chk("pre_rst_regw", 32'(RegWrite), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_regw", 32'(RegWrite), 0);
    chk("async_memw", 32'(MemWrite), 0);
    chk("async_flags", 32'(Flags), 0);
    chk("async_fetch", 32'(FetchCnt), 0);
    reset = 1'b1;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
